// File: rtl/spi_flash_writer_if.sv
// spi_flash_writer_if: word-write request bus between a host and spi_flash_writer
// wstrb/word_address/wdata carry a one-word program request; wbusy/status report progress.
interface spi_flash_writer_if;
  logic        wstrb;
  logic [21:0] word_address;
  logic [31:0] wdata;
  logic        wbusy;
  logic [7:0]  status;
  modport master (output wstrb, word_address, wdata, input wbusy, status);
  modport slave (input wstrb, word_address, wdata, output wbusy, status);
endinterface

// File: rtl/spi_flash_writer.sv
// spi_flash_writer: programs one 32-bit word into SPI NOR flash (WREN, PAGE PROGRAM, RDSR poll)
// Ports: clk, reset (async, active-high); bus (slave: wstrb, word_address, wdata in; wbusy, status out);
//        CLK, CS_N, MOSI to the flash; MISO from the flash.
module spi_flash_writer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  spi_flash_writer_if.slave bus,
  output logic CLK,
  output logic CS_N,
  output logic MOSI,
  input  logic MISO
);
  typedef enum logic [2:0] {IDLE, WREN, GAP1, PROG, GAP2, POLL, GAP3} state_t;
  localparam logic [6:0] GAP_LD = 7'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [6:0] cnt, cnt_n;
  logic [63:0] sh, sh_n;
  logic [7:0] status, status_n;
  logic [53:0] frame, frame_n;
  logic done, active;
  assign done = cnt == 7'd0;
  assign active = state == WREN || state == PROG || state == POLL;
  assign CS_N = ~active;
  // SPI clock rises mid-cycle, so MOSI (updated on clk posedge) is stable at its rising edge
  assign CLK = active & ~clk;
  assign MOSI = sh[63];
  assign bus.wbusy = state != IDLE;
  assign bus.status = status;
  always_comb begin
    state_n = state;
    cnt_n = done ? 7'd0 : cnt - 7'd1;
    // status bits enter at the bottom during the last 8 POLL cycles; zeros are shifted in elsewhere
    sh_n = {sh[62:0], (state == POLL && cnt < 7'd8) ? MISO : 1'b0};
    status_n = status;
    frame_n = frame;
    case (state)
      IDLE: if (bus.wstrb) begin
        state_n = WREN;
        cnt_n = 7'd7;
        sh_n = {8'h06, 56'd0};
        frame_n = {bus.word_address, bus.wdata};
      end
      WREN: if (done) begin
        state_n = GAP1;
        cnt_n = GAP_LD;
        sh_n = '0;
      end
      GAP1: if (done) begin
        state_n = PROG;
        cnt_n = 7'd63;
        sh_n = {8'h02, frame[53:32], 2'b00, frame[7:0], frame[15:8], frame[23:16], frame[31:24]};
      end
      PROG: if (done) begin
        state_n = GAP2;
        cnt_n = GAP_LD;
        sh_n = '0;
      end
      GAP2, GAP3: if (done) begin
        state_n = POLL;
        cnt_n = 7'd15;
        sh_n = {8'h05, 56'd0};
      end
      POLL: if (done) begin
        status_n = {sh[6:0], MISO};
        state_n = MISO ? GAP3 : IDLE;
        cnt_n = MISO ? GAP_LD : 7'd0;
        sh_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      status <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      status <= status_n;
      frame <= frame_n;
    end
  end
endmodule
